// File: rtl/sub_pkg.sv
// Shared definitions for the serial borrow subtractor: FSM state encoding
// and the default operand width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: {bout,d} = a - b - bin, one bit per clock, LSB
// first, with the borrow rippled through a flop between bit cycles.
// Optional signed-overflow output is enabled by defining OVF_FLAG_EN.
// Timing: start accepted at edge N; bits are processed at edges N+1..N+WIDTH;
// at edge N+WIDTH+1 the results are published and done pulses for one cycle.
module serial_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             bit_diff;
  logic             bit_bo;

`ifdef OVF_FLAG_EN
  // Operand sign bits shift out during RUN, so keep them for the flag.
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_stage (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bi   (borrow),
    .diff (bit_diff),
    .bo   (bit_bo)
  );

  // FSM with operand/result datapath and registered outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the shift chain order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
`ifdef OVF_FLAG_EN
      ovf    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef OVF_FLAG_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            // All bits processed: publish the result in one step.
            d     <= work;
            bout  <= borrow;
            done  <= 1'b1;
            state <= DONE;
`ifdef OVF_FLAG_EN
            ovf   <= (a_msb != b_msb) && (work[WIDTH-1] != a_msb);
`endif
          end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            work   <= {bit_diff, work[WIDTH-1:1]};
            borrow <= bit_bo;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor (WIDTH=4). Define
// OVF_FLAG_EN at compile time to also check the overflow output.
module tb_serial_borrow_subtractor;

  localparam int W       = 4;
  localparam int LATENCY = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction reduced modulo 2^(W+1).
  function automatic logic [W:0] ref_sub(input int aa, input int bb, input int bi);
    int r;
    r = aa - bb - bi;
    return (W+1)'(r & ((1 << (W + 1)) - 1));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic [W-1:0] dd);
    return (aa[W-1] != bb[W-1]) && (dd[W-1] != aa[W-1]);
  endfunction

  // Launch one operation (accepted at the next rising edge), wait for done.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                        output int lat, output bit seen);
    @(negedge clk);
    a = aa; b = bb; bin = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Compare outputs at the done cycle against the model.
  task automatic check_result(input string name, input logic [W-1:0] aa,
                              input logic [W-1:0] bb, input logic bi,
                              input int lat, input bit seen);
    logic [W:0] exp;
    exp = ref_sub(int'(aa), int'(bb), int'(bi));
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: done never seen within bound", name);
    end else if (lat !== LATENCY) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, LATENCY);
    end
    n_checks++;
    if ({bout, d} !== exp) begin
      n_fail++;
      $display("FAIL %s result: got bout=%b d=%b required bout=%b d=%b",
               name, bout, d, exp[W], exp[W-1:0]);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy at done: got %b required 1", name, busy);
    end
`ifdef OVF_FLAG_EN
    n_checks++;
    if (ovf !== ref_ovf(aa, bb, exp[W-1:0])) begin
      n_fail++;
      $display("FAIL %s ovf: got %b required %b", name, ovf, ref_ovf(aa, bb, exp[W-1:0]));
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, bout, d} !== '0) begin
      n_fail++;
      $display("FAIL reset_under_rst: got busy=%b done=%b bout=%b d=%b required all 0",
               busy, done, bout, d);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, bout, d} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b bout=%b d=%b required all 0",
               busy, done, bout, d);
    end
  endtask

  task automatic test_directed();
    int lat;
    bit seen;
    logic [W-1:0] va [5] = '{4'b0011, 4'b1100, 4'b0000, 4'b1010, 4'b0111};
    logic [W-1:0] vb [5] = '{4'b1100, 4'b0011, 4'b1111, 4'b1010, 4'b1000};
    logic         vi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // Hand-derived expectations, independent of the model function.
    logic [W:0]   ve [5] = '{5'b1_0111, 5'b0_1001, 5'b1_0000, 5'b0_0000, 5'b1_1111};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vi[i], lat, seen);
      check_result($sformatf("directed%0d", i), va[i], vb[i], vi[i], lat, seen);
      n_checks++;
      if ({bout, d} !== ve[i]) begin
        n_fail++;
        $display("FAIL directed%0d_table: got %b required %b", i, {bout, d}, ve[i]);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_done_width: got done=%b required 0", i, done);
      end
    end
`ifdef OVF_FLAG_EN
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_case: got ovf=%b required 1", ovf);
    end
`endif
  endtask

  task automatic test_random();
    int lat;
    bit seen;
    logic [W-1:0] ra, rb;
    logic ri;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ri = 1'($urandom);
      run_op(ra, rb, ri, lat, seen);
      check_result($sformatf("random%0d", i), ra, rb, ri, lat, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] prev_exp;
    logic [W:0] exp1;
    int edges;
    int n_done;
    bit seen;
    prev_exp = ref_sub(int'(4'b0111), int'(4'b1000), 0);
    exp1     = ref_sub(int'(4'b0011), int'(4'b1100), 0);
    // Previous op left 0111 - 1000 = 1_1111 on the outputs.
    @(negedge clk);
    a = 4'b0011; b = 4'b1100; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      edges = i;
      if (i == 2) begin
        a = 4'b1111; b = 4'b0001; bin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 3) begin
        n_checks++;
        if ({bout, d} !== prev_exp) begin
          n_fail++;
          $display("FAIL hold_during_run: got %b required %b", {bout, d}, prev_exp);
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || edges !== LATENCY || {bout, d} !== exp1) begin
      n_fail++;
      $display("FAIL ignore_start_busy: seen=%b edges=%0d got %b required %b after %0d",
               seen, edges, {bout, d}, exp1, LATENCY);
    end
    // Start coinciding with done must also be dropped.
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: got %b required 0", busy);
    end
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0 || busy !== 1'b0 || {bout, d} !== exp1) begin
      n_fail++;
      $display("FAIL single_done: extra dones=%0d busy=%b got %b required 0 dones, busy 0, %b",
               n_done, busy, {bout, d}, exp1);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int lat;
    bit seen;
    @(negedge clk);
    a = 4'b0101; b = 4'b0110; bin = 1'b1; start = 1'b1;
    @(posedge clk);          // accepted; 1st RUN cycle follows
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);          // 2nd RUN cycle follows
    @(posedge clk);          // 3rd RUN cycle follows
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || d !== '0 || bout !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%b done=%b d=%b bout=%b required all 0",
               busy, done, d, bout);
    end
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", n_done);
    end
    run_op(4'b1001, 4'b0100, 1'b0, lat, seen);
    check_result("after_reset", 4'b1001, 4'b0100, 1'b0, lat, seen);
  endtask

  // Rst and start together: rst must win.
  task automatic test_reset_priority();
    @(negedge clk);
    a = 4'b0001; b = 4'b0010; bin = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: got busy=%b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
